bin_to_bcd_signed: RTL and testbench

//  Sequential signed-binary to sign-magnitude BCD converter (shift-add-3), one input bit per clock.

---
 rtl/bin_to_bcd_signed.sv | 114 +++++++++++
 tb/tb_bin_to_bcd_signed.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_signed.sv
// Signed binary to sign-magnitude BCD converter.
// Shift-add-3, one input bit per clock, saturating on overflow.
module bin_to_bcd_signed #(
  parameter int IN_WIDTH = 24,
  parameter int DIGITS   = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   value,
  output logic                  busy,
  output logic                  done,
  output logic                  signBit,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  overflow
);

  localparam int SW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [SW-1:0]       scr;
  logic [SW-1:0]       scr_adj;
  logic [IN_WIDTH-1:0] mag;
  logic [IN_WIDTH-1:0] mag_abs;
  logic [CW-1:0]       cnt;
  logic                neg;
  logic                ovf;

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // next-state: IDLE -> SHIFT on start, SHIFT until last bit, one FINISH cycle
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // magnitude of the operand; the most negative value maps to 2^(IN_WIDTH-1)
  always_comb begin
    mag_abs = value;
    if (value[IN_WIDTH-1]) mag_abs = ~value + IN_WIDTH'(1);
  end

  // add 3 to every scratch digit >= 5 before it is shifted
  always_comb begin
    scr_adj = scr;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (scr[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
    end
  end

  // any nonzero extra top digit means the magnitude exceeds the display
  assign ovf = |scr[SW-1 -: 4];

  // datapath: capture, shift, and publish results on the FINISH edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      signBit  <= 1'b0;
      BCD      <= '0;
      overflow <= 1'b0;
      scr      <= '0;
      mag      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            neg  <= value[IN_WIDTH-1] & (|value);
            mag  <= mag_abs;
            scr  <= '0;
            cnt  <= CW'(IN_WIDTH);
            busy <= 1'b1;
          end
        end
        SHIFT: begin
          {scr, mag} <= {scr_adj[SW-2:0], mag, 1'b0};
          cnt        <= cnt - CW'(1);
        end
        FINISH: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          signBit  <= neg;
          overflow <= ovf;
          if (ovf) BCD <= {DIGITS{4'h9}};
          else     BCD <= scr[4*DIGITS-1:0];
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_signed.sv
// Testbench for bin_to_bcd_signed.
// Directed and random conversions against an arithmetic model.
module tb_bin_to_bcd_signed;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [23:0] value;
  logic        busy;
  logic        done;
  logic        signBit;
  logic [23:0] BCD;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int kcyc   = 0;

  logic [23:0] last_bcd = '0;
  logic        last_sgn = 1'b0;
  logic        last_ovf = 1'b0;

  bin_to_bcd_signed dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .signBit  (signBit),
    .BCD      (BCD),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [23:0] v, output logic s,
                                output logic [23:0] b, output logic o);
    int sv;
    int m;
    sv = int'($signed(v));
    m  = (sv < 0) ? -sv : sv;
    s  = (sv < 0);
    o  = (m > 999999);
    b  = '0;
    if (o) b = 24'h999999;
    else begin
      for (int i = 0; i < 6; i++) begin
        b[4*i +: 4] = 4'(m % 10);
        m = m / 10;
      end
    end
  endfunction

  // assert start for one edge; returns at the negedge after the sampling edge
  task automatic kick(input logic [23:0] v);
    start = 1'b1;
    value = v;
    @(negedge clk);
    kcyc  = cyc;
    start = 1'b0;
    value = $urandom;
  endtask

  // wait for done (bounded) and check latency and results
  task automatic finish_check(input string tag, input logic [23:0] v);
    logic        s;
    logic [23:0] b;
    logic        o;
    while (done !== 1'b1 && (cyc - kcyc) < 40) @(negedge clk);
    model(v, s, b, o);
    chk({tag, "_lat"}, 32'(cyc - kcyc), 32'd25);
    chk({tag, "_busy0"}, 32'(busy), 32'd0);
    chk({tag, "_sign"}, 32'(signBit), 32'(s));
    chk({tag, "_bcd"}, 32'(BCD), 32'(b));
    chk({tag, "_ovf"}, 32'(overflow), 32'(o));
    last_bcd = b;
    last_sgn = s;
    last_ovf = o;
  endtask

  // full conversion with a mid-flight hold check
  task automatic run(input string tag, input logic [23:0] v);
    kick(v);
    chk({tag, "_busy1"}, 32'(busy), 32'd1);
    repeat (12) @(negedge clk);
    chk({tag, "_hold"}, 32'({last_ovf, last_sgn, BCD}),
        32'({overflow, signBit, last_bcd}));
    finish_check(tag, v);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    logic [23:0] rv;
    reset_n = 1'b0;
    start   = 1'b0;
    value   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sign", 32'(signBit), 32'd0);
    chk("rst_bcd", 32'(BCD), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run("zero", 24'd0);
    run("m123", 24'hFFFF85);
    run("p999999", 24'd999999);
    run("p1000000", 24'd1000000);
    run("most_neg", 24'h800000);
    run("most_pos", 24'h7FFFFF);
    run("m999999", -24'sd999999);
    run("m1000000", -24'sd1000000);
    run("m1", 24'hFFFFFF);
    run("p1", 24'd1);

    kick(24'd4321);
    repeat (4) @(negedge clk);
    start = 1'b1;
    value = 24'd777;
    @(negedge clk);
    start = 1'b0;
    finish_check("busy_ign", 24'd4321);
    kick(24'd42);
    chk("b2b_done_low", 32'(done), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    finish_check("b2b", 24'd42);

    repeat (5) @(negedge clk);
    chk("idle_hold", 32'(BCD), 32'(last_bcd));

    kick(-24'sd56);
    while ((cyc - kcyc) < 10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_out", 32'({busy, done, signBit, overflow, BCD}), 32'd0);
    reset_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort_nodone", 32'(ndone), 32'd0);
    last_bcd = '0;
    last_sgn = 1'b0;
    last_ovf = 1'b0;
    run("m56", -24'sd56);

    for (int i = 0; i < 24; i++) begin
      rv = 24'($urandom);
      if (i % 3 == 0) rv = 24'($urandom_range(0, 999999));
      if (i % 3 == 1) rv = -24'($urandom_range(0, 999999));
      run("rand", rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
